// File: rtl/sift_dir_pkg.sv
// ============================================================================
//  Module      : sift_dir_pkg
//  Description : Shared constants, cos magnitude table and FSM state type
//                for the SIFT descriptor-window coordinate generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sift_dir_pkg;

  localparam int DIR_W     = 5;
  localparam int NBINS     = 32;
  localparam int TRIG_FRAC = 6;

  // |cos(k * 11.25 deg)| in Q1.6 for k = 0..8; sin(k) is COS_MAG[8-k]
  localparam logic [7:0] COS_MAG [0:8] = '{
    8'd64, 8'd63, 8'd59, 8'd53, 8'd45, 8'd36, 8'd24, 8'd12, 8'd0
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/dir_cossin_lut.sv
// ============================================================================
//  Module      : dir_cossin_lut
//  Description : Combinational 5-bit direction bin to signed Q1.6 cos/sin.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dir_cossin_lut
  import sift_dir_pkg::*;
(
  input  logic [DIR_W-1:0]  i_dir,
  output logic signed [7:0] o_cos,
  output logic signed [7:0] o_sin
);

  logic [2:0]        w_k;
  logic [3:0]        w_kc;
  logic signed [7:0] w_mc;
  logic signed [7:0] w_ms;

  assign w_k  = i_dir[2:0];
  assign w_kc = 4'd8 - {1'b0, w_k};
  assign w_mc = $signed(COS_MAG[w_k]);
  assign w_ms = $signed(COS_MAG[w_kc]);

  // Quadrant folding: each step of dir[4:3] is a further 90 degree rotation
  always_comb begin
    o_cos = w_mc;
    o_sin = w_ms;
    case (i_dir[4:3])
      2'd1: begin
        o_cos = -w_ms;
        o_sin = w_mc;
      end
      2'd2: begin
        o_cos = -w_mc;
        o_sin = -w_ms;
      end
      2'd3: begin
        o_cos = w_ms;
        o_sin = -w_mc;
      end
      default: begin
        o_cos = w_mc;
        o_sin = w_ms;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dir_rot_coord_gen.sv
// ============================================================================
//  Module      : dir_rot_coord_gen
//  Description : Streams rotated 16x16 descriptor sample offsets for a
//                keypoint orientation bin, one per cycle, valid/ready output.
//                Optional out_oob flag enabled by macro DIR_ROT_OOB_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dir_rot_coord_gen #(
  parameter int WIN       = 16,
  parameter int COORD_W   = 8,
  parameter int TRIG_FRAC = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_valid,
  output logic                            start_ready,
  input  logic [sift_dir_pkg::DIR_W-1:0]  dir,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic signed [COORD_W-1:0]       out_dx,
  output logic signed [COORD_W-1:0]       out_dy,
  output logic [7:0]                      out_idx,
  output logic                            out_last,
  output logic                            busy
`ifdef DIR_ROT_OOB_EN
  ,
  output logic                            out_oob
`endif
);

  import sift_dir_pkg::*;

  localparam logic [7:0]        c_LAST = 8'(WIN * WIN - 1);
  localparam logic signed [12:0] c_RND = 13'(2 ** (TRIG_FRAC - 1));

  state_t r_state;
  state_t w_state_nxt;

  logic [7:0]         r_cnt;
  logic signed [7:0]  r_cos;
  logic signed [7:0]  r_sin;
  logic signed [7:0]  w_lut_cos;
  logic signed [7:0]  w_lut_sin;

  logic               w_adv;
  logic               w_start;
  logic               w_issue;
  logic               w_last_hs;

  logic signed [5:0]  w_u;
  logic signed [5:0]  w_v;
  logic signed [12:0] w_u13;
  logic signed [12:0] w_v13;
  logic signed [12:0] w_cos13;
  logic signed [12:0] w_sin13;

  logic               r_s1_valid;
  logic [7:0]         r_s1_idx;
  logic signed [12:0] r_s1_uc;
  logic signed [12:0] r_s1_vs;
  logic signed [12:0] r_s1_us;
  logic signed [12:0] r_s1_vc;

  logic signed [12:0]        w_rx_rnd;
  logic signed [12:0]        w_ry_rnd;
  logic signed [COORD_W-1:0] w_dx;
  logic signed [COORD_W-1:0] w_dy;

  logic                      r_out_valid;
  logic signed [COORD_W-1:0] r_out_dx;
  logic signed [COORD_W-1:0] r_out_dy;
  logic [7:0]                r_out_idx;
  logic                      r_out_last;

  dir_cossin_lut u_lut (
    .i_dir (dir),
    .o_cos (w_lut_cos),
    .o_sin (w_lut_sin)
  );

  // A single advance enable freezes the whole pipe while the output stalls
  assign w_adv     = !r_out_valid || out_ready;
  assign w_start   = start_valid && start_ready;
  assign w_issue   = (r_state == RUN) && w_adv;
  assign w_last_hs = r_out_valid && r_out_last && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    start_ready = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        start_ready = !rst;
        busy        = 1'b0;
        if (w_start) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_issue && (r_cnt == c_LAST)) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_last_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Sample centres in half-pixel units: u = 2x - 15, v = 2y - 15
  assign w_u     = $signed({1'b0, r_cnt[3:0], 1'b1}) - 6'sd16;
  assign w_v     = $signed({1'b0, r_cnt[7:4], 1'b1}) - 6'sd16;
  assign w_u13   = $signed({{7{w_u[5]}}, w_u});
  assign w_v13   = $signed({{7{w_v[5]}}, w_v});
  assign w_cos13 = $signed({{5{r_cos[7]}}, r_cos});
  assign w_sin13 = $signed({{5{r_sin[7]}}, r_sin});

  assign w_rx_rnd = r_s1_uc - r_s1_vs + c_RND;
  assign w_ry_rnd = r_s1_us + r_s1_vc + c_RND;
  assign w_dx     = COORD_W'(w_rx_rnd >>> TRIG_FRAC);
  assign w_dy     = COORD_W'(w_ry_rnd >>> TRIG_FRAC);

`ifdef DIR_ROT_OOB_EN
  localparam logic signed [COORD_W-1:0] c_HALF = COORD_W'(WIN - 1);
  logic r_out_oob;
  logic w_oob;
  assign w_oob = (w_dx > c_HALF) || (w_dx < -c_HALF) ||
                 (w_dy > c_HALF) || (w_dy < -c_HALF);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_cos       <= '0;
      r_sin       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_idx    <= '0;
      r_s1_uc     <= '0;
      r_s1_vs     <= '0;
      r_s1_us     <= '0;
      r_s1_vc     <= '0;
      r_out_valid <= 1'b0;
      r_out_dx    <= '0;
      r_out_dy    <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
`ifdef DIR_ROT_OOB_EN
      r_out_oob   <= 1'b0;
`endif
    end else begin
      if (w_start) begin
        r_cos <= w_lut_cos;
        r_sin <= w_lut_sin;
        r_cnt <= '0;
      end else if (w_issue) begin
        r_cnt <= r_cnt + 8'd1;
      end

      if (w_adv) begin
        r_s1_valid <= w_issue;
        if (w_issue) begin
          r_s1_idx <= r_cnt;
          r_s1_uc  <= w_u13 * w_cos13;
          r_s1_vs  <= w_v13 * w_sin13;
          r_s1_us  <= w_u13 * w_sin13;
          r_s1_vc  <= w_v13 * w_cos13;
        end

        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_dx   <= w_dx;
          r_out_dy   <= w_dy;
          r_out_idx  <= r_s1_idx;
          r_out_last <= (r_s1_idx == c_LAST);
`ifdef DIR_ROT_OOB_EN
          r_out_oob  <= w_oob;
`endif
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_dx    = r_out_dx;
  assign out_dy    = r_out_dy;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
`ifdef DIR_ROT_OOB_EN
  assign out_oob   = r_out_oob;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dir_rot_coord_gen.sv
// ============================================================================
//  Module      : tb_dir_rot_coord_gen
//  Description : Scoreboard bench for dir_rot_coord_gen (trig model from
//                real-valued sin/cos, spot values, latency, stall, reset).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dir_rot_coord_gen;

  logic              clk;
  logic              rst;
  logic              start_valid;
  logic              start_ready;
  logic [4:0]        dir;
  logic              out_valid;
  logic              out_ready;
  logic signed [7:0] out_dx;
  logic signed [7:0] out_dy;
  logic [7:0]        out_idx;
  logic              out_last;
  logic              busy;
`ifdef DIR_ROT_OOB_EN
  logic              out_oob;
`endif

  dir_rot_coord_gen #(
    .WIN       (16),
    .COORD_W   (8),
    .TRIG_FRAC (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .dir         (dir),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_dx      (out_dx),
    .out_dy      (out_dy),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .busy        (busy)
`ifdef DIR_ROT_OOB_EN
    ,
    .out_oob     (out_oob)
`endif
  );

  typedef struct {
    int dx;
    int dy;
    int idx;
    bit oob;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t hold_e;

  int n_cmp     = 0;
  int n_err     = 0;
  int cyc       = 0;
  int t_start   = 0;
  int n_out     = 0;
  int cur_dir   = 0;
  bit win_stall = 1'b0;

  // {dir, idx, dx, dy}
  int spot [9][4] = '{
    '{0, 0,   -15, -15}, '{0, 15,  15, -15}, '{0, 255, 15,  15},
    '{8, 0,    15, -15}, '{8, 15,  15,  15}, '{8, 240, -15, -15},
    '{4, 0,     0, -21}, '{4, 255,  0,  21}, '{4, 15,  21,   0}
  };

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int trig(input int d, input bit is_sin);
    real a;
    real r;
    a = real'(d) * 11.25 * 3.14159265358979 / 180.0;
    r = is_sin ? $sin(a) : $cos(a);
    return int'(r * 64.0);
  endfunction

  function automatic exp_t model(input int d, input int idx);
    exp_t e;
    int u, v, c, s, rx, ry;
    u  = 2 * (idx % 16) - 15;
    v  = 2 * (idx / 16) - 15;
    c  = trig(d, 1'b0);
    s  = trig(d, 1'b1);
    rx = u * c - v * s;
    ry = u * s + v * c;
    e.dx  = (rx + 32) >>> 6;
    e.dy  = (ry + 32) >>> 6;
    e.idx = idx;
    e.oob = (e.dx > 15) || (e.dx < -15) || (e.dy > 15) || (e.dy < -15);
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      check_eq("sb_has_entry", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        check_eq("idx", out_idx, mon_e.idx);
        check_eq("dx", out_dx, mon_e.dx);
        check_eq("dy", out_dy, mon_e.dy);
        check_eq("last", out_last, (mon_e.idx == 255));
`ifdef DIR_ROT_OOB_EN
        check_eq("oob", out_oob, mon_e.oob);
`endif
        if (n_out == 0) check_eq("lat_first", cyc, t_start + 3);
        if (mon_e.idx == 255 && !win_stall) check_eq("lat_last", cyc, t_start + 258);
        for (int i = 0; i < 9; i++) begin
          if (spot[i][0] == cur_dir && spot[i][1] == int'(out_idx)) begin
            check_eq("spot_dx", out_dx, spot[i][2]);
            check_eq("spot_dy", out_dy, spot[i][3]);
          end
        end
      end
      n_out++;
    end
  end

  task automatic start_win(input int d);
    int k;
    @(posedge clk);
    #1;
    dir         = 5'(d);
    start_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!start_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("start_ready", start_ready, 1);
    t_start   = cyc;
    n_out     = 0;
    cur_dir   = d;
    win_stall = 1'b0;
    for (int i = 0; i < 256; i++) sb.push_back(model(d, i));
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    dir         = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 2000);
    check_eq("done_in_time", (k < 2000), 1);
    check_eq("out_count", n_out, 256);
    check_eq("sb_drained", sb.size(), 0);
  endtask

  task automatic wait_idx(input int idx);
    int k;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!(out_valid && int'(out_idx) == idx) && k < 400);
    check_eq("reach_idx", out_idx, idx);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    dir         = 5'd0;
    out_ready   = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_start_ready", start_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_dx", out_dx, 0);
    check_eq("rst_dy", out_dy, 0);
    check_eq("rst_idx", out_idx, 0);
    check_eq("rst_last", out_last, 0);
`ifdef DIR_ROT_OOB_EN
    check_eq("rst_oob", out_oob, 0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_start_ready", start_ready, 1);
    check_eq("post_rst_busy", busy, 0);

    // dir 0 with a foreign start request mid-run
    start_win(0);
    repeat (20) @(posedge clk);
    #1;
    start_valid = 1'b1;
    dir         = 5'd3;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("busy_in_run", busy, 1);
    check_eq("no_ready_in_run", start_ready, 0);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    wait_done();

    start_win(8);
    wait_done();
    start_win(4);
    wait_done();

    // output stall on idx 100
    start_win(5);
    wait_idx(100);
    out_ready = 1'b0;
    win_stall = 1'b1;
    hold_e    = model(5, 100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_idx", out_idx, 100);
      check_eq("stall_dx", out_dx, hold_e.dx);
      check_eq("stall_dy", out_dy, hold_e.dy);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_done();

    // reset pulse mid-window
    start_win(0);
    wait_idx(50);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_start_ready", start_ready, 1);
    repeat (3) @(negedge clk);
    check_eq("abort_quiet", out_valid, 0);

    start_win(20);
    wait_done();
    start_win(27);
    wait_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
